// File: rtl/inert_pkg.sv
// Shared types and command tables for the inertial sensor sequencer.
// Holds the FSM state encoding, the sensor config/read command words and the capture strobe base.
package inert_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    CFG_ISSUE,
    CFG_WAIT,
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_CAPT,
    VALID
  } state_t;

  // Index 0 is the first word written after power-up.
  localparam logic [3:0][15:0] CFG_CMDS = {16'h1460, 16'h1150, 16'h1053, 16'h0D02};

  // Index 0 is roll_L; index 7 is AZ_H.
  localparam logic [7:0][15:0] RD_CMDS = {
    16'hAD00, 16'hAC00, 16'hAB00, 16'hAA00,
    16'hA700, 16'hA600, 16'hA500, 16'hA400
  };

  localparam logic [7:0] CTRL_BASE = 8'b1000_0000;

endpackage

// File: rtl/int_sync.sv
// Brings the asynchronous data-ready interrupt into the clk domain
// and produces a one-cycle pulse on each synchronized rising edge.
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync_reg;
  logic       prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], async_in};
      prev_reg <= sync_reg[1];
    end
  end

  assign rise = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/inert_seq.sv
// Inertial sensor sequencer: waits out power-up, writes the sensor configuration over SPI,
// then on each data-ready interrupt reads the 8 sample bytes and strobes them into the register bank.
module inert_seq
  import inert_pkg::*;
#(
  parameter int INIT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [7:0]  ctrl,
  output logic        vld,
  output logic        busy
);

  localparam int                CNT_W    = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       cfg_idx_reg, cfg_idx_next;
  logic [2:0]       rd_idx_reg, rd_idx_next;
  logic             pending_reg, pending_next;
  logic [15:0]      cmd_reg, cmd_next;
  logic             int_rise;

  int_sync u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (INT),
    .rise     (int_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= PWRUP;
      cnt_reg     <= '0;
      cfg_idx_reg <= 2'd0;
      rd_idx_reg  <= 3'd0;
      pending_reg <= 1'b0;
      cmd_reg     <= 16'h0000;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cfg_idx_reg <= cfg_idx_next;
      rd_idx_reg  <= rd_idx_next;
      pending_reg <= pending_next;
      cmd_reg     <= cmd_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cfg_idx_next = cfg_idx_reg;
    rd_idx_next  = rd_idx_reg;
    // Only one interrupt is remembered; extra edges while one is pending merge into it.
    pending_next = pending_reg | int_rise;
    cmd_next     = cmd_reg;

    case (state_reg)
      PWRUP: begin
        if (cnt_reg == CNT_LAST) begin
          state_next   = CFG_ISSUE;
          cfg_idx_next = 2'd0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      CFG_ISSUE: state_next = CFG_WAIT;
      CFG_WAIT: begin
        if (done) begin
          if (cfg_idx_reg == 2'd3) begin
            state_next = IDLE;
          end else begin
            cfg_idx_next = cfg_idx_reg + 2'd1;
            state_next   = CFG_ISSUE;
          end
        end
      end
      IDLE: begin
        if (pending_reg) begin
          state_next   = RD_ISSUE;
          rd_idx_next  = 3'd0;
          // An edge landing on the very cycle the burst starts is kept for the next burst.
          pending_next = int_rise;
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (done) state_next = RD_CAPT;
      end
      RD_CAPT: begin
        if (rd_idx_reg == 3'd7) begin
          state_next = VALID;
        end else begin
          rd_idx_next = rd_idx_reg + 3'd1;
          state_next  = RD_ISSUE;
        end
      end
      VALID:   state_next = IDLE;
      default: state_next = PWRUP;
    endcase

    // Load the command word as the issue state is entered so it is stable from wrt until done.
    if (state_next == CFG_ISSUE) begin
      cmd_next = CFG_CMDS[cfg_idx_next];
    end else if (state_next == RD_ISSUE) begin
      cmd_next = RD_CMDS[rd_idx_next];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ctrl
      assign ctrl[gi] = (state_reg == RD_CAPT) && ((CTRL_BASE >> rd_idx_reg) == (8'(1) << gi));
    end
  endgenerate

  assign wrt  = (state_reg == CFG_ISSUE) || (state_reg == RD_ISSUE);
  assign vld  = (state_reg == VALID);
  assign busy = (state_reg != IDLE);
  assign cmd  = cmd_reg;

endmodule
